out_pkt_arbiter: RTL
====================

# out_pkt_arbiter

Packet-level round-robin arbiter for two AXI-Stream sources sharing one output stream at the data-route egress. It grants one source per packet and holds the grant until that source's tlast beat is accepted, so beats from the two sources never mix. Output is a registered full-throughput skid stage with backpressure from the downstream sink. It also provides per-source completed-packet counters for debug.

## Interface
- DWIDTH, 128, tdata width of all streams
- CNT_W, 16, width of packet counters

- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low; registers clear immediately on assertion
- s_axis_tdata_0  in  DWIDTH  source 0 data
- s_axis_tvalid_0  in  1  source 0 valid
- s_axis_tready_0  out  1  source 0 ready
- s_axis_tlast_0  in  1  source 0 end of packet
- s_axis_tdata_1 / s_axis_tvalid_1 / s_axis_tready_1 / s_axis_tlast_1: same for source 1
- m_axis_tdata  out  DWIDTH  merged data
- m_axis_tvalid  out  1  merged valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  merged end of packet
- grant  out  2  one-hot current owner; 2'b00 when idle
- pkt_cnt_0  out  CNT_W  packets completed from source 0
- pkt_cnt_1  out  CNT_W  packets completed from source 1

## Operation
- FSM states: IDLE, OWN0, OWN1. Reset state IDLE.
- IDLE: only valid_0 -> OWN0; only valid_1 -> OWN1; both -> source not served last (rr pointer); neither -> stay. After reset, rr pointer favours source 0.
- OWNx: s_axis_tready_x = stage_ready; other source tready = 0. Beat accepted when tvalid_x & tready_x.
- Accepted beat with tlast=1 in OWNx -> IDLE next cycle; rr pointer := x; pkt_cnt_x += 1 (wraps modulo 2^CNT_W).
- Grant held until tlast regardless of tvalid gaps inside a packet; a source dropping tvalid mid-packet stalls the arbiter (no timeout).
- In IDLE both treadys = 0; no beat accepted.
- Output stage: 2-entry skid buffer (main + skid register) carrying {tdata, tlast}. stage_ready = ~skid_full (registered). Beats leave in acceptance order; no loss, no duplication under any m_axis_tready pattern.
- grant = one-hot of state (OWN0 -> 01, OWN1 -> 10, IDLE -> 00).
- Reset mid-operation: FSM -> IDLE, buffered beats dropped, rr pointer -> favour 0, counters -> 0; truncated packet is not completed downstream.

## Timing
- Reset values: s_axis_tready_0/1 = 0, m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tlast = 0, grant = 00, pkt_cnt_0/1 = 0.
- Arbitration latency: tvalid seen in IDLE at cycle N -> OWNx and tready_x high at N+1 (if stage_ready).
- Data latency: beat accepted at cycle N appears on m_axis at N+1 when output empty.
- Throughput: 1 beat/cycle within a packet with m_axis_tready high; one idle cycle between packets (tlast accept at M, IDLE at M+1, next grant at M+2). Packet of L beats occupies L+1 cycles.
- m_axis_tvalid/tdata/tlast stable while m_axis_tvalid & ~m_axis_tready.
- tready outputs registered-derived; no combinational path from m_axis_tready to s_axis_tready_x.

## Test plan
- Source 0 alone sends 4-beat packet 0xA0..0xA3, m_axis_tready=1 -> grant=01 from cycle 1, output 0xA0..0xA3 cycles 2..5 with tlast on 0xA3, pkt_cnt_0=1, grant=00 after.
- Both sources assert valid at cycle 0 with 3-beat packets continuously -> grant order 01,10,01,10; output packets alternate intact, never interleaved; counters advance equally.
- Source 1 alone, m_axis_tready toggles 1,0,0,1 repeating during 8-beat packet -> all 8 beats delivered once in order, output held stable during stalls, s_axis_tready_1 drops when skid full.
- Back-to-back 1-beat packets from both sources -> one beat per 2 cycles, strict alternation 0,1,0,1, tlast=1 on every output beat.
- rst_n asserted asynchronously mid-cycle during beat 2 of a 5-beat packet -> all outputs 0 immediately, grant=00, counters 0; after release, new source-1 packet granted first-come.
- 2^CNT_W+1 one-beat packets from source 0 -> pkt_cnt_0 wraps to 1.

Source files
------------

// File: rtl/out_pkt_arbiter_if.sv
// Stream bundle for the two-source packet arbiter: two AXI-Stream sources in,
// one merged AXI-Stream out. The slave modport is the arbiter's view.
interface out_pkt_arbiter_if #(
    parameter int DWIDTH = 128
);
    logic [DWIDTH-1:0] s_axis_tdata_0;
    logic              s_axis_tvalid_0;
    logic              s_axis_tready_0;
    logic              s_axis_tlast_0;

    logic [DWIDTH-1:0] s_axis_tdata_1;
    logic              s_axis_tvalid_1;
    logic              s_axis_tready_1;
    logic              s_axis_tlast_1;

    logic [DWIDTH-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;

    modport slave (
        input  s_axis_tdata_0, s_axis_tvalid_0, s_axis_tlast_0,
        output s_axis_tready_0,
        input  s_axis_tdata_1, s_axis_tvalid_1, s_axis_tlast_1,
        output s_axis_tready_1,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        input  m_axis_tready
    );

    modport master (
        output s_axis_tdata_0, s_axis_tvalid_0, s_axis_tlast_0,
        input  s_axis_tready_0,
        output s_axis_tdata_1, s_axis_tvalid_1, s_axis_tlast_1,
        input  s_axis_tready_1,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        output m_axis_tready
    );
endinterface

// File: rtl/out_pkt_arbiter.sv
// Packet-level round-robin arbiter: two AXI-Stream sources share one output
// through a registered two-entry skid stage; grant is held until tlast.
module out_pkt_arbiter #(
    parameter int DWIDTH = 128,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    out_pkt_arbiter_if.slave axis,
    output logic [1:0]       grant,
    output logic [CNT_W-1:0] pkt_cnt_0,
    output logic [CNT_W-1:0] pkt_cnt_1
);
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] OWN0 = 2'b01;
    localparam logic [1:0] OWN1 = 2'b10;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              favour_1;

    logic              main_valid;
    logic [DWIDTH-1:0] main_data;
    logic              main_last;
    logic              skid_valid;
    logic [DWIDTH-1:0] skid_data;
    logic              skid_last;

    logic              stage_ready;
    logic              main_load;
    logic              acc_0;
    logic              acc_1;
    logic              in_fire;
    logic [DWIDTH-1:0] in_data;
    logic              in_last;
    logic              done_0;
    logic              done_1;

    // Ready depends only on registered state, so m_axis_tready never reaches
    // the source-side tready combinationally.
    assign stage_ready          = ~skid_valid;
    assign axis.s_axis_tready_0 = (state == OWN0) & stage_ready;
    assign axis.s_axis_tready_1 = (state == OWN1) & stage_ready;

    assign acc_0   = axis.s_axis_tvalid_0 & axis.s_axis_tready_0;
    assign acc_1   = axis.s_axis_tvalid_1 & axis.s_axis_tready_1;
    assign in_fire = acc_0 | acc_1;
    assign in_data = acc_1 ? axis.s_axis_tdata_1 : axis.s_axis_tdata_0;
    assign in_last = acc_1 ? axis.s_axis_tlast_1 : axis.s_axis_tlast_0;
    assign done_0  = acc_0 & axis.s_axis_tlast_0;
    assign done_1  = acc_1 & axis.s_axis_tlast_1;

    assign grant = {state == OWN1, state == OWN0};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (axis.s_axis_tvalid_0 && (!axis.s_axis_tvalid_1 || !favour_1)) begin
                    state_nxt = OWN0;
                end else if (axis.s_axis_tvalid_1) begin
                    state_nxt = OWN1;
                end
            end
            OWN0:    if (done_0) state_nxt = IDLE;
            OWN1:    if (done_1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            favour_1  <= 1'b0;
            pkt_cnt_0 <= '0;
            pkt_cnt_1 <= '0;
        end else begin
            state <= state_nxt;
            if (done_0) begin
                favour_1  <= 1'b1;
                pkt_cnt_0 <= pkt_cnt_0 + 1'b1;
            end
            if (done_1) begin
                favour_1  <= 1'b0;
                pkt_cnt_1 <= pkt_cnt_1 + 1'b1;
            end
        end
    end

    // Main register refills whenever it is empty or being consumed; the skid
    // register only catches a beat accepted while main is stalled. Since
    // stage_ready = ~skid_valid, a skid drain and a new accept never coincide.
    assign main_load = ~main_valid | axis.m_axis_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_last  <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_last  <= 1'b0;
        end else if (main_load) begin
            if (skid_valid) begin
                main_valid <= 1'b1;
                main_data  <= skid_data;
                main_last  <= skid_last;
                skid_valid <= 1'b0;
            end else begin
                main_valid <= in_fire;
                if (in_fire) begin
                    main_data <= in_data;
                    main_last <= in_last;
                end
            end
        end else if (in_fire) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
            skid_last  <= in_last;
        end
    end

    assign axis.m_axis_tvalid = main_valid;
    assign axis.m_axis_tdata  = main_data;
    assign axis.m_axis_tlast  = main_last;

endmodule
